// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: fetch port, data port and RAM port bundle for bus_arbiter
//   slave  : arbiter side (drives readies, read data, RAM controls, stall_req)
//   master : environment side (requesters and RAM)
//   ADDR_W : width of the RAM word address
interface bus_arbiter_if #(
   parameter int ADDR_W = 20
);
   logic              if_req;
   logic [31:0]       if_addr;
   logic [31:0]       if_rdata;
   logic              if_ready;
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;
   logic              ram_ce;
   logic              ram_we;
   logic [3:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic              stall_req;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
      output if_rdata, if_ready, mem_rdata, mem_ready,
      output ram_ce, ram_we, ram_be, ram_addr, ram_wdata, stall_req
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
      input  if_rdata, if_ready, mem_rdata, mem_ready,
      input  ram_ce, ram_we, ram_be, ram_addr, ram_wdata, stall_req
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-port RAM between an instruction-fetch port and a data port
//   clk         : system clock, rising edge
//   rst         : asynchronous reset, active low
//   bus (slave) : fetch request/response, data request/response, RAM port, stall_req
//   WAIT_CYCLES : extra RAM wait cycles per access (0..7)
//   ADDR_W      : RAM word address width
//   BUS_ARB_FAIR_EN : when defined, ties alternate between the ports instead of favouring data
module bus_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 20
) (
   input  logic         clk,
   input  logic         rst,
   bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            r_state, w_next;
   logic [2:0]        r_cnt;
   logic              r_own;
   logic              r_ce, r_we;
   logic [3:0]        r_be;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_if_rdata, r_mem_rdata;
   logic              w_req, w_gnt_mem, w_if_ready, w_mem_ready, w_unused;

   assign w_req = bus.if_req | bus.mem_req;

`ifdef BUS_ARB_FAIR_EN
   // Reset points priority at the data port; afterwards a tie goes to the port not served last
   logic r_mem_first;
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_mem_first <= 1'b1;
      else if (r_state == IDLE && w_req) r_mem_first <= ~w_gnt_mem;
   assign w_gnt_mem = bus.mem_req & (~bus.if_req | r_mem_first);
`else
   assign w_gnt_mem = bus.mem_req;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = IDLE;
      w_next = (r_state == IDLE) ? (w_req ? BUSY : IDLE) :
               (r_state == BUSY) ? ((r_cnt == 3'd0) ? RESP : BUSY) : IDLE;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_cnt       <= 3'd0;
         r_own       <= 1'b0;
         r_ce        <= 1'b0;
         r_we        <= 1'b0;
         r_be        <= 4'd0;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_if_rdata  <= 32'd0;
         r_mem_rdata <= 32'd0;
      end else begin
         r_ce <= (w_next == BUSY);
         if (r_state == IDLE && w_req) begin
            r_own   <= w_gnt_mem;
            r_cnt   <= 3'(WAIT_CYCLES);
            r_we    <= w_gnt_mem & bus.mem_we;
            r_be    <= w_gnt_mem ? bus.mem_be : 4'hF;
            r_addr  <= w_gnt_mem ? bus.mem_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
            r_wdata <= w_gnt_mem ? bus.mem_wdata : 32'd0;
         end else if (r_state == BUSY) begin
            if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            else begin
               // last BUSY cycle: RAM data is valid now, strobes drop as we leave BUSY
               r_we <= 1'b0;
               r_be <= 4'd0;
               if (!r_we && r_own) r_mem_rdata <= bus.ram_rdata;
               if (!r_we && !r_own) r_if_rdata <= bus.ram_rdata;
            end
         end
      end

   assign w_if_ready  = (r_state == RESP) & ~r_own;
   assign w_mem_ready = (r_state == RESP) & r_own;

   assign bus.if_ready  = w_if_ready;
   assign bus.mem_ready = w_mem_ready;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.mem_rdata = r_mem_rdata;
   assign bus.ram_ce    = r_ce;
   assign bus.ram_we    = r_we;
   assign bus.ram_be    = r_be;
   assign bus.ram_addr  = r_addr;
   assign bus.ram_wdata = r_wdata;
   assign bus.stall_req = (bus.if_req & ~w_if_ready) | (bus.mem_req & ~w_mem_ready);

   // byte-offset and out-of-range address bits carry no meaning for the RAM
   assign w_unused = &{1'b0, bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                       bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors, corner sequences and a randomized transaction-level model
module tb_bus_arbiter;
   localparam int W = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bus_arbiter_if #(.ADDR_W(20)) b ();
   bus_arbiter_if #(.ADDR_W(20)) b0 ();

   bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20)) dut  (.clk(clk), .rst(rst), .bus(b));
   bus_arbiter #(.WAIT_CYCLES(0), .ADDR_W(20)) dut0 (.clk(clk), .rst(rst), .bus(b0));

   logic [31:0] ram [16];
   logic [31:0] refm [16];
   logic        ovr_en = 1'b0;
   logic [31:0] ovr = 32'd0;

   assign b.ram_rdata  = ovr_en ? ovr : ram[b.ram_addr[3:0]];
   assign b0.ram_rdata = 32'h0BAD_F00D;

   function automatic logic [31:0] init_word(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
   endfunction

   always @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
      end else if (b.ram_ce && b.ram_we) begin
         for (int i = 0; i < 4; i++)
            if (b.ram_be[i]) ram[b.ram_addr[3:0]][8*i +: 8] <= b.ram_wdata[8*i +: 8];
      end

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        fetch;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic [19:0] e_addr;
      logic [3:0]  e_be;
   } vec_t;

   vec_t tv [5];
   int   order [$];
   int   exp_o [4];

   task automatic idle_inputs();
      b.if_req = 1'b0;  b.if_addr = 32'd0;
      b.mem_req = 1'b0; b.mem_we = 1'b0; b.mem_be = 4'd0; b.mem_addr = 32'd0; b.mem_wdata = 32'd0;
      b0.if_req = 1'b0;  b0.if_addr = 32'd0;
      b0.mem_req = 1'b0; b0.mem_we = 1'b0; b0.mem_be = 4'd0; b0.mem_addr = 32'd0; b0.mem_wdata = 32'd0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      ovr_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] pi, pm;
      @(negedge clk);
      pi = b.if_rdata;
      pm = b.mem_rdata;
      ovr_en = 1'b1;
      ovr = v.rd;
      if (v.fetch) begin
         b.if_req = 1'b1; b.if_addr = v.addr;
      end else begin
         b.mem_req = 1'b1; b.mem_we = v.we; b.mem_be = v.be; b.mem_addr = v.addr; b.mem_wdata = v.wdata;
      end
      for (int c = 1; c <= W + 2; c++) begin
         @(negedge clk);
         chkb("vec_ram_ce", b.ram_ce, c <= W + 1);
         if (c <= W + 1) begin
            chk("vec_ram_addr", 32'(b.ram_addr), 32'(v.e_addr));
            chk("vec_ram_be", 32'(b.ram_be), 32'(v.e_be));
            chkb("vec_ram_we", b.ram_we, v.we & ~v.fetch);
            if (!v.fetch && v.we) chk("vec_ram_wdata", b.ram_wdata, v.wdata);
         end else begin
            chk("vec_idle_be", 32'(b.ram_be), 32'd0);
            chkb("vec_idle_we", b.ram_we, 1'b0);
         end
         chkb("vec_if_ready", b.if_ready, v.fetch && c == W + 2);
         chkb("vec_mem_ready", b.mem_ready, !v.fetch && c == W + 2);
      end
      chk("vec_if_rdata", b.if_rdata, v.fetch ? v.rd : pi);
      chk("vec_mem_rdata", b.mem_rdata, (!v.fetch && !v.we) ? v.rd : pm);
      idle_inputs();
      ovr_en = 1'b0;
   endtask

   int          cyc, free, if_at, mem_at;
   logic        prio_mem, gm;
   logic [3:0]  a;
   logic [31:0] exp_if, exp_mem, last_if, last_mem;

   initial begin
      tv[0] = '{1'b1, 1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h3421_0001, 20'h00004, 4'hF};
      tv[1] = '{1'b0, 1'b1, 4'b0011, 32'h8000_0104, 32'hDEAD_BEEF, 32'h1111_2222, 20'h00041, 4'b0011};
      tv[2] = '{1'b0, 1'b0, 4'b0101, 32'h0000_0100, 32'h0,         32'hCAFE_0100, 20'h00040, 4'b0101};
      tv[3] = '{1'b1, 1'b0, 4'h0,    32'hFFFF_FFFF, 32'h0,         32'h0F0F_F0F0, 20'hFFFFF, 4'hF};
      tv[4] = '{1'b0, 1'b1, 4'b1100, 32'h003F_FFFE, 32'h1234_5678, 32'h0,         20'hFFFFF, 4'b1100};

      idle_inputs();
      repeat (3) @(negedge clk);
      chkb("rst_ram_ce", b.ram_ce, 1'b0);
      chkb("rst_ram_we", b.ram_we, 1'b0);
      chk("rst_ram_be", 32'(b.ram_be), 32'd0);
      chkb("rst_if_ready", b.if_ready, 1'b0);
      chkb("rst_mem_ready", b.mem_ready, 1'b0);
      chk("rst_if_rdata", b.if_rdata, 32'd0);
      chk("rst_mem_rdata", b.mem_rdata, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(tv[i]);

      // both ports raised on the same edge: data first, fetch follows
      pulse_reset();
      @(negedge clk);
      ovr_en = 1'b1; ovr = 32'h5555_AAAA;
      b.if_req = 1'b1;  b.if_addr = 32'h0000_0010;
      b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_be = 4'hF; b.mem_addr = 32'h0000_0100;
      for (int c = 1; c <= 2 * W + 5; c++) begin
         @(negedge clk);
         chkb("both_mem_ready", b.mem_ready, c == W + 2);
         chkb("both_if_ready", b.if_ready, c == 2 * W + 5);
         chkb("both_stall", b.stall_req, c <= 2 * W + 4);
         if (b.mem_ready) b.mem_req = 1'b0;
         if (b.if_ready) b.if_req = 1'b0;
      end
      idle_inputs();

      // reset in the first BUSY cycle aborts the access
      @(negedge clk);
      ovr = 32'h7777_0000;
      b.if_req = 1'b1; b.if_addr = 32'h0000_0010;
      @(negedge clk);
      chkb("mid_busy_ce", b.ram_ce, 1'b1);
      #1 rst = 1'b0;
      #1;
      chkb("mid_rst_ce", b.ram_ce, 1'b0);
      chkb("mid_rst_if_ready", b.if_ready, 1'b0);
      chk("mid_rst_if_rdata", b.if_rdata, 32'd0);
      chk("mid_rst_mem_rdata", b.mem_rdata, 32'd0);
      idle_inputs();
      ovr_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chkb("post_rst_ce", b.ram_ce, 1'b0);
      chkb("post_rst_ready", b.if_ready, 1'b0);
      run_vec(tv[0]);

      // both requests held continuously
      pulse_reset();
      order.delete();
      @(negedge clk);
      ovr_en = 1'b1; ovr = 32'h0000_C0DE;
      b.if_req = 1'b1;  b.if_addr = 32'h0000_0020;
      b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_be = 4'hF; b.mem_addr = 32'h0000_0200;
      for (int c = 1; c <= 3 * (W + 3) + W + 2; c++) begin
         @(negedge clk);
         if (b.if_ready) order.push_back(0);
         if (b.mem_ready) order.push_back(1);
      end
      idle_inputs();
      ovr_en = 1'b0;
`ifdef BUS_ARB_FAIR_EN
      exp_o = '{1, 0, 1, 0};
`else
      exp_o = '{1, 1, 1, 1};
`endif
      chk("held_grants", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk("held_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_o[i]));
      repeat (W + 3) @(negedge clk);

      // zero-wait instance: one BUSY cycle, ready two cycles after sample
      @(negedge clk);
      b0.if_req = 1'b1; b0.if_addr = 32'h0000_0010;
      @(negedge clk);
      chkb("w0_ce_c1", b0.ram_ce, 1'b1);
      chk("w0_addr_c1", 32'(b0.ram_addr), 32'h4);
      chkb("w0_ready_c1", b0.if_ready, 1'b0);
      @(negedge clk);
      chkb("w0_ce_c2", b0.ram_ce, 1'b0);
      chkb("w0_ready_c2", b0.if_ready, 1'b1);
      chk("w0_rdata", b0.if_rdata, 32'h0BAD_F00D);
      b0.if_req = 1'b0;
      @(negedge clk);
      chkb("w0_ready_c3", b0.if_ready, 1'b0);

      // randomized traffic against a transaction-level model
      pulse_reset();
      for (int i = 0; i < 16; i++) refm[i] = init_word(i);
      cyc = 0; free = 0; if_at = -1; mem_at = -1; prio_mem = 1'b1;
      last_if = 32'd0; last_mem = 32'd0; exp_if = 32'd0; exp_mem = 32'd0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         cyc++;
         if (cyc >= free && (b.if_req || b.mem_req)) begin
            gm = b.mem_req && (!b.if_req || prio_mem);
`ifdef BUS_ARB_FAIR_EN
            prio_mem = !gm;
`endif
            free = cyc + W + 3;
            if (gm) begin
               a = b.mem_addr[5:2];
               mem_at = cyc + W + 1;
               if (b.mem_we) begin
                  for (int k = 0; k < 4; k++)
                     if (b.mem_be[k]) refm[a][8*k +: 8] = b.mem_wdata[8*k +: 8];
                  exp_mem = last_mem;
               end else exp_mem = refm[a];
            end else begin
               a = b.if_addr[5:2];
               if_at = cyc + W + 1;
               exp_if = refm[a];
            end
         end
         if (cyc == if_at) last_if = exp_if;
         if (cyc == mem_at) last_mem = exp_mem;
         chkb("rnd_if_ready", b.if_ready, cyc == if_at);
         chkb("rnd_mem_ready", b.mem_ready, cyc == mem_at);
         chk("rnd_if_rdata", b.if_rdata, last_if);
         chk("rnd_mem_rdata", b.mem_rdata, last_mem);
         chkb("rnd_stall", b.stall_req, (b.if_req && cyc != if_at) || (b.mem_req && cyc != mem_at));
         if (b.if_req) begin
            if (b.if_ready) b.if_req = 1'b0;
         end else if ($urandom_range(2) == 0) begin
            b.if_req = 1'b1; b.if_addr = $urandom;
         end
         if (b.mem_req) begin
            if (b.mem_ready) b.mem_req = 1'b0;
         end else if ($urandom_range(2) == 0) begin
            b.mem_req = 1'b1; b.mem_we = 1'($urandom_range(1)); b.mem_be = 4'($urandom);
            b.mem_addr = $urandom; b.mem_wdata = $urandom;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
